// File: rtl/pintar_display_mux.sv
// pintar_display_mux: output stage of the two-digit 7-segment display path.
// Chooses the units or tens segment pattern, registers it onto the shared
// segment bus and drives the matching active-low digit anodes. The digit is
// either chosen manually (En_decena) or by a free-running refresh scanner.
//
// Ports:
//   clk        system clock, rising-edge
//   rst        synchronous active-high reset
//   auto_scan  1 = scanner selects digit, 0 = En_decena selects digit
//   En_decena  manual select (1 = tens, 0 = units), used when auto_scan = 0
//   cSegU      units-digit pattern, active-low, bit6 = g .. bit0 = a
//   cSegD      tens-digit pattern, same encoding
//   cSeg       registered segment bus
//   an         registered active-low anodes, an[0] = units, an[1] = tens
//   digit_sel  registered digit shown, 1 = tens, 0 = units
module pintar_display_mux #(
  parameter int unsigned SCAN_DIV  = 100000,
  parameter logic [6:0]  SEG_BLANK = 7'b1111111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       auto_scan,
  input  logic       En_decena,
  input  logic [6:0] cSegU,
  input  logic [6:0] cSegD,
  output logic [6:0] cSeg,
  output logic [1:0] an,
  output logic       digit_sel
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SCAN_DIV - 1);

  logic [CntW-1:0] scanCnt, scanCntNext;
  logic            scanBit, scanBitNext;
  logic            selEff;
  logic [6:0]      segNext;
  logic [1:0]      anNext;
  logic            digitSelNext;

  // Next-state: free-running scanner plus output selection.
  always_comb begin
    scanCntNext  = scanCnt + CntW'(1);
    scanBitNext  = scanBit;
    selEff       = En_decena;
    segNext      = cSegU;
    anNext       = 2'b10;
    digitSelNext = 1'b0;

    // Scan bit flips on the wrap edge, so each digit owns SCAN_DIV cycles.
    if (scanCnt == CntLast) begin
      scanCntNext = '0;
      scanBitNext = ~scanBit;
    end

    if (auto_scan) begin
      selEff = scanBit;
    end

    if (selEff) begin
      segNext      = cSegD;
      anNext       = 2'b01;
      digitSelNext = 1'b1;
    end
  end

  // State and output registers; all outputs update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      scanCnt   <= '0;
      scanBit   <= 1'b0;
      cSeg      <= SEG_BLANK;
      an        <= 2'b11;
      digit_sel <= 1'b0;
    end else begin
      scanCnt   <= scanCntNext;
      scanBit   <= scanBitNext;
      cSeg      <= segNext;
      an        <= anNext;
      digit_sel <= digitSelNext;
    end
  end

endmodule

// File: tb/tb_pintar_display_mux.sv
// Testbench for pintar_display_mux: constant vector table, hand sequences for
// scan/reset corners, and randomized stimulus against a reference model.
module tb_pintar_display_mux;

  localparam int unsigned Div = 4;
  localparam logic [6:0] Blank = 7'b1111111;

  logic       clk;
  logic       rst;
  logic       auto_scan;
  logic       En_decena;
  logic [6:0] cSegU;
  logic [6:0] cSegD;
  logic [6:0] cSeg;
  logic [1:0] an;
  logic       digit_sel;

  int passCnt  = 0;
  int totalCnt = 0;
  int edgesSinceReset = 0;   // non-reset edges since the last reset
  logic [9:0] modelExp;

  pintar_display_mux #(.SCAN_DIV(Div), .SEG_BLANK(Blank)) dut (
    .clk(clk), .rst(rst), .auto_scan(auto_scan), .En_decena(En_decena),
    .cSegU(cSegU), .cSegD(cSegD), .cSeg(cSeg), .an(an), .digit_sel(digit_sel)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst;
    logic       autoScan;
    logic       enDecena;
    logic [6:0] segU;
    logic [6:0] segD;
    logic [6:0] expSeg;
    logic [1:0] expAn;
    logic       expSel;
  } vec_t;

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got seg=%b an=%b sel=%b, want seg=%b an=%b sel=%b",
                  name, act[9:3], act[2:1], act[0], exp[9:3], exp[2:1], exp[0]);
  endtask

  // Model: scanner digit = which SCAN_DIV-long slot since reset, parity.
  task automatic step(input string name);
    logic sel;
    @(posedge clk);
    if (rst) begin
      modelExp = {Blank, 2'b11, 1'b0};
      edgesSinceReset = 0;
    end else begin
      sel = auto_scan ? logic'((edgesSinceReset / Div) % 2) : En_decena;
      modelExp = sel ? {cSegD, 2'b01, 1'b1} : {cSegU, 2'b10, 1'b0};
      edgesSinceReset++;
    end
    #1;
    chk(name, {cSeg, an, digit_sel}, modelExp);
  endtask

  task automatic drive(input logic r, input logic a, input logic e,
                       input logic [6:0] u, input logic [6:0] d);
    rst = r; auto_scan = a; En_decena = e; cSegU = u; cSegD = d;
  endtask

  vec_t vecs[$];

  initial begin
    drive(1'b1, 1'b0, 1'b1, 7'b1000000, 7'b0000000);

    // rst, auto, en, segU, segD, expSeg, expAn, expSel
    vecs.push_back('{1'b1, 1'b0, 1'b1, 7'b1000000, 7'b0000000, 7'b1111111, 2'b11, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b1, 7'b1000000, 7'b0000000, 7'b1111111, 2'b11, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 7'b1000000, 7'b1111111, 7'b1111111, 2'b01, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 7'b1000000, 7'b1111111, 7'b1000000, 2'b10, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 7'b1111001, 7'b1111111, 7'b1111001, 2'b10, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 7'b0100100, 7'b0100100, 7'b0100100, 2'b01, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 7'b0100100, 7'b0100100, 7'b0100100, 2'b10, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 7'b0010010, 7'b0000010, 7'b0000010, 2'b01, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 1'b1, 7'b0010010, 7'b0000010, 7'b1111111, 2'b11, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].autoScan, vecs[i].enDecena, vecs[i].segU, vecs[i].segD);
      step("table_model");
      chk("table_vec", {cSeg, an, digit_sel},
          {vecs[i].expSeg, vecs[i].expAn, vecs[i].expSel});
    end

    // Manual select: output must hold until the next edge.
    drive(1'b0, 1'b0, 1'b1, 7'b1000000, 7'b1111111);
    step("manual_tens");
    chk("manual_tens_const", {cSeg, an, digit_sel}, {7'b1111111, 2'b01, 1'b1});
    En_decena = 1'b0;
    #2;
    chk("no_comb_path", {cSeg, an, digit_sel}, {7'b1111111, 2'b01, 1'b1});
    step("manual_units");
    chk("manual_units_const", {cSeg, an, digit_sel}, {7'b1000000, 2'b10, 1'b0});

    // Auto-scan from a fresh reset; En_decena noise must be ignored.
    drive(1'b1, 1'b1, 1'b0, 7'b1000000, 7'b1111001);
    step("scan_reset");
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      En_decena = 1'($urandom);
      step("scan_model");
      if (((i / Div) % 2) == 1)
        chk("scan_tens", {cSeg, an, digit_sel}, {7'b1111001, 2'b01, 1'b1});
      else
        chk("scan_units", {cSeg, an, digit_sel}, {7'b1000000, 2'b10, 1'b0});
    end

    // Reset mid-scan, then the first slot after release is units.
    for (int i = 0; i < int'($urandom_range(1, 7)); i++) step("scan_pre_rst");
    rst = 1'b1;
    step("mid_rst_model");
    chk("mid_rst_const", {cSeg, an, digit_sel}, {Blank, 2'b11, 1'b0});
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      En_decena = 1'($urandom);
      step("post_rst_model");
      if (i < 4) chk("post_rst_units", {cSeg, an, digit_sel}, {7'b1000000, 2'b10, 1'b0});
      else       chk("post_rst_tens",  {cSeg, an, digit_sel}, {7'b1111001, 2'b01, 1'b1});
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 24) == 0), 1'($urandom), 1'($urandom),
            7'($urandom), 7'($urandom));
      if ((i % 50) < 30) auto_scan = 1'b1;
      step("random");
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
